// File: rtl/jpeg_rle_stream_encoder.sv
// jpeg_rle_stream_encoder
//   Turns a zig-zag ordered stream of quantized coefficients (one per input
//   handshake) into JPEG entropy symbols for the Huffman packer:
//     DC difference, AC (run,size,amplitude), ZRL (15,0,0) and EOB (0,0,0).
//
//   Ports
//     clk, rst_n      clock, asynchronous active-low reset
//     in_valid/in_ready/in_coef   coefficient input (signed, COEF_W bits)
//     dc_clr          clears the DC predictor; only looked at when the DC
//                     coefficient of a block is accepted
//     out_valid/out_ready         symbol output handshake
//     out_run, out_size, out_amp  symbol fields; out_amp is right-aligned and
//                     zero above out_size
//     out_dc, out_eob, out_last   symbol is DC / is EOB / ends the block
//
//   Handshake: a transfer happens on a clock edge where valid && ready. The
//   output is a single register slot; while out_valid && !out_ready every
//   out_* field holds. A new symbol loads only when !out_valid || out_ready.
//
//   Optional build macro JPEG_RLE_STATS_EN adds blk_nz_cnt (nonzero
//   coefficients of the finished block, DC included) and blk_done (high
//   during the transfer of the out_last symbol).
//
//   The FSM state is available as the signal `state_q` (type state_t) for
//   debug probes and bound checkers.

module jpeg_rle_stream_encoder #(
  parameter int COEF_W  = 11,
  parameter int BLK_LEN = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  input  logic                     dc_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_run,
  output logic [3:0]               out_size,
  output logic [COEF_W:0]          out_amp,
  output logic                     out_dc,
  output logic                     out_eob,
  output logic                     out_last
`ifdef JPEG_RLE_STATS_EN
  ,
  output logic [$clog2(BLK_LEN):0] blk_nz_cnt,
  output logic                     blk_done
`endif
);

  localparam int IDX_W = $clog2(BLK_LEN);
  localparam int AMP_W = COEF_W + 1;
  // The run counter must be able to represent 32 for the ZRL exit test even
  // for tiny blocks, so it never drops below 6 bits.
  localparam int RUN_W = (IDX_W + 1 > 6) ? IDX_W + 1 : 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);

  typedef enum logic [1:0] {
    ACCEPT   = 2'd0,
    EMIT_ZRL = 2'd1,
    EMIT_SYM = 2'd2
  } state_t;

  // Magnitude category: index of the highest set bit of |v|, plus one.
  function automatic logic [3:0] mag_size(input logic signed [AMP_W-1:0] v);
    logic [AMP_W-1:0] mag;
    mag_size = 4'd0;
    mag = v[AMP_W-1] ? ((~v) + AMP_W'(1)) : v;
    for (int i = 0; i < AMP_W; i++) begin
      if (mag[i]) mag_size = 4'(i + 1);
    end
  endfunction

  // Negative values are sent as (v-1) truncated to size bits, which equals
  // the ones complement of |v|. The wrap of v-1 at the most negative value
  // is harmless because only the low size bits survive.
  function automatic logic [AMP_W-1:0] amp_bits(input logic signed [AMP_W-1:0] v,
                                                input logic [3:0] size);
    logic [AMP_W-1:0] raw;
    raw = v[AMP_W-1] ? (v - AMP_W'(1)) : v;
    amp_bits = '0;
    for (int i = 0; i < AMP_W; i++) begin
      if (i < int'(size)) amp_bits[i] = raw[i];
    end
  endfunction

  state_t                    state_q, state_n;
  logic [IDX_W-1:0]          idx_q, idx_n;
  logic [RUN_W-1:0]          run_q, run_n;
  logic signed [COEF_W-1:0]  dc_pred_q, dc_pred_n;
  logic signed [COEF_W-1:0]  lat_coef_q, lat_coef_n;
  logic                      lat_last_q, lat_last_n;

  logic                      out_valid_n, out_dc_n, out_eob_n, out_last_n;
  logic [3:0]                out_run_n, out_size_n;
  logic [AMP_W-1:0]          out_amp_n;

  logic                      slot_free, accept, is_last_idx, coef_zero;
  logic signed [AMP_W-1:0]   coef_ext, pred_ext, lat_ext, dc_diff, sym_src;
  logic [3:0]                sym_size;
  logic [AMP_W-1:0]          sym_amp;

  assign slot_free   = !out_valid || out_ready;
  assign in_ready    = (state_q == ACCEPT) && slot_free;
  assign accept      = in_valid && in_ready;
  assign is_last_idx = (idx_q == LAST_IDX);
  assign coef_zero   = (in_coef == '0);

  // All arithmetic is one bit wider than a coefficient so the DC difference
  // cannot overflow.
  assign coef_ext = {in_coef[COEF_W-1], in_coef};
  assign pred_ext = dc_clr ? '0 : {dc_pred_q[COEF_W-1], dc_pred_q};
  assign lat_ext  = {lat_coef_q[COEF_W-1], lat_coef_q};
  assign dc_diff  = coef_ext - pred_ext;

  // One shared size/amplitude encoder serves DC, AC and the deferred symbol.
  always_comb begin
    sym_src = coef_ext;
    if (state_q == EMIT_SYM)  sym_src = lat_ext;
    else if (idx_q == '0)     sym_src = dc_diff;
  end

  assign sym_size = mag_size(sym_src);
  assign sym_amp  = amp_bits(sym_src, sym_size);

  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    run_n       = run_q;
    dc_pred_n   = dc_pred_q;
    lat_coef_n  = lat_coef_q;
    lat_last_n  = lat_last_q;
    out_valid_n = out_valid && !out_ready;
    out_run_n   = out_run;
    out_size_n  = out_size;
    out_amp_n   = out_amp;
    out_dc_n    = out_dc;
    out_eob_n   = out_eob;
    out_last_n  = out_last;

    case (state_q)
      ACCEPT: begin
        if (accept) begin
          idx_n = is_last_idx ? '0 : idx_q + IDX_W'(1);
          if (idx_q == '0) begin
            out_valid_n = 1'b1;
            out_run_n   = 4'd0;
            out_size_n  = sym_size;
            out_amp_n   = sym_amp;
            out_dc_n    = 1'b1;
            out_eob_n   = 1'b0;
            out_last_n  = 1'b0;
            dc_pred_n   = in_coef;
            run_n       = '0;
          end else if (coef_zero) begin
            if (is_last_idx) begin
              // Trailing zeros collapse into EOB; any pending ZRLs vanish.
              out_valid_n = 1'b1;
              out_run_n   = 4'd0;
              out_size_n  = 4'd0;
              out_amp_n   = '0;
              out_dc_n    = 1'b0;
              out_eob_n   = 1'b1;
              out_last_n  = 1'b1;
              run_n       = '0;
            end else begin
              run_n = run_q + RUN_W'(1);
            end
          end else if (run_q < RUN_W'(16)) begin
            out_valid_n = 1'b1;
            out_run_n   = run_q[3:0];
            out_size_n  = sym_size;
            out_amp_n   = sym_amp;
            out_dc_n    = 1'b0;
            out_eob_n   = 1'b0;
            out_last_n  = is_last_idx;
            run_n       = '0;
          end else begin
            // Run too long for one symbol: park the coefficient and emit
            // ZRLs first.
            lat_coef_n = in_coef;
            lat_last_n = is_last_idx;
            state_n    = EMIT_ZRL;
          end
        end
      end

      EMIT_ZRL: begin
        if (slot_free) begin
          out_valid_n = 1'b1;
          out_run_n   = 4'd15;
          out_size_n  = 4'd0;
          out_amp_n   = '0;
          out_dc_n    = 1'b0;
          out_eob_n   = 1'b0;
          out_last_n  = 1'b0;
          run_n       = run_q - RUN_W'(16);
          if (run_q < RUN_W'(32)) state_n = EMIT_SYM;
        end
      end

      EMIT_SYM: begin
        if (slot_free) begin
          out_valid_n = 1'b1;
          out_run_n   = run_q[3:0];
          out_size_n  = sym_size;
          out_amp_n   = sym_amp;
          out_dc_n    = 1'b0;
          out_eob_n   = 1'b0;
          out_last_n  = lat_last_q;
          run_n       = '0;
          state_n     = ACCEPT;
        end
      end

      default: state_n = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCEPT;
      idx_q      <= '0;
      run_q      <= '0;
      dc_pred_q  <= '0;
      lat_coef_q <= '0;
      lat_last_q <= 1'b0;
      out_valid  <= 1'b0;
      out_run    <= '0;
      out_size   <= '0;
      out_amp    <= '0;
      out_dc     <= 1'b0;
      out_eob    <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      run_q      <= run_n;
      dc_pred_q  <= dc_pred_n;
      lat_coef_q <= lat_coef_n;
      lat_last_q <= lat_last_n;
      out_valid  <= out_valid_n;
      out_run    <= out_run_n;
      out_size   <= out_size_n;
      out_amp    <= out_amp_n;
      out_dc     <= out_dc_n;
      out_eob    <= out_eob_n;
      out_last   <= out_last_n;
    end
  end

`ifdef JPEG_RLE_STATS_EN
  // nz_acc_q counts the block in flight; nz_last_q snapshots the finished
  // block when its last coefficient is accepted, because the next block's
  // DC may be accepted in the same cycle the last symbol transfers.
  logic [IDX_W:0] nz_acc_q, nz_last_q, nz_inc;

  assign nz_inc   = {{IDX_W{1'b0}}, !coef_zero};
  assign blk_done = out_valid && out_ready && out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_acc_q   <= '0;
      nz_last_q  <= '0;
      blk_nz_cnt <= '0;
    end else begin
      if (accept) begin
        if (is_last_idx) begin
          nz_acc_q  <= '0;
          nz_last_q <= nz_acc_q + nz_inc;
        end else begin
          nz_acc_q  <= nz_acc_q + nz_inc;
        end
      end
      if (blk_done) blk_nz_cnt <= nz_last_q;
    end
  end
`endif

endmodule

// File: tb/tb_jpeg_rle_stream_encoder.sv
// Testbench for jpeg_rle_stream_encoder (COEF_W=11, BLK_LEN=64).
// Expected symbols are hand-computed and queued in exp_q; a monitor pops one
// entry per output transfer. Table-driven AC vectors plus directed blocks.

module tb_jpeg_rle_stream_encoder;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [10:0] in_coef;
  logic               dc_clr;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_run;
  logic [3:0]         out_size;
  logic [11:0]        out_amp;
  logic               out_dc;
  logic               out_eob;
  logic               out_last;
`ifdef JPEG_RLE_STATS_EN
  logic [6:0]         blk_nz_cnt;
  logic               blk_done;
`endif

  jpeg_rle_stream_encoder #(.COEF_W(11), .BLK_LEN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .dc_clr    (dc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_run   (out_run),
    .out_size  (out_size),
    .out_amp   (out_amp),
    .out_dc    (out_dc),
    .out_eob   (out_eob),
    .out_last  (out_last)
`ifdef JPEG_RLE_STATS_EN
    ,
    .blk_nz_cnt(blk_nz_cnt),
    .blk_done  (blk_done)
`endif
  );

  typedef struct {
    logic signed [10:0] ac;
    logic [3:0]         size;
    logic [11:0]        amp;
  } vec_t;

  vec_t               vecs[10];
  logic [22:0]        exp_q[$];
  logic signed [10:0] blk[64];
  int                 tests, fails;
  int                 rx_cnt, lowrdy_cnt, done_cnt;
  logic               track_en, ready_rand, ready_hold;
  logic               prev_stall;
  logic [22:0]        prev_sym, cur_sym, exp_sym;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push(input logic dc, input logic eob, input logic last,
                      input logic [3:0] run, input logic [3:0] size, input logic [11:0] amp);
    exp_q.push_back({dc, eob, last, run, size, amp});
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = '0;
  endtask

  // driver
  task automatic drive_coef(input logic signed [10:0] c, input logic clr);
    int budget;
    budget = 500;
    in_valid = 1'b1;
    in_coef  = c;
    dc_clr   = clr;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget--;
      if (budget == 0) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: got no in_ready expected in_ready within 500 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dc_clr   = 1'b0;
  endtask

  task automatic send_block(input logic clr);
    for (int i = 0; i < 64; i++) drive_coef(blk[i], (i == 0) ? clr : 1'b0);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 2000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d symbols pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // out_ready source: random or held level
  task automatic ready_loop();
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_hold;
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      cur_sym = {out_dc, out_eob, out_last, out_run, out_size, out_amp};
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && out_valid) begin
          tests++;
          if (cur_sym !== prev_sym) begin
            fails++;
            $display("FAIL hold: got %h expected %h", cur_sym, prev_sym);
          end
        end
        if (out_valid && out_ready) begin
          rx_cnt++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sym_extra: got %h expected no symbol", cur_sym);
          end else begin
            exp_sym = exp_q.pop_front();
            if (cur_sym !== exp_sym) begin
              fails++;
              $display("FAIL sym: got %h expected %h", cur_sym, exp_sym);
            end
          end
        end
`ifdef JPEG_RLE_STATS_EN
        if (blk_done) done_cnt++;
`endif
        if (track_en && !in_ready) lowrdy_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_sym   = cur_sym;
      end
    end
  endtask

  initial begin
    int rx0;
    tests = 0; fails = 0; rx_cnt = 0; lowrdy_cnt = 0; done_cnt = 0;
    track_en = 1'b0; ready_rand = 1'b0; ready_hold = 1'b1; prev_stall = 1'b0;
    prev_sym = '0; cur_sym = '0; exp_sym = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_coef = '0; dc_clr = 1'b0; out_ready = 1'b1;

    vecs[0] = '{11'sd1,     4'd1,  12'h001};
    vecs[1] = '{-11'sd1,    4'd1,  12'h000};
    vecs[2] = '{11'sd2,     4'd2,  12'h002};
    vecs[3] = '{-11'sd2,    4'd2,  12'h001};
    vecs[4] = '{11'sd5,     4'd3,  12'h005};
    vecs[5] = '{-11'sd3,    4'd2,  12'h000};
    vecs[6] = '{-11'sd7,    4'd3,  12'h000};
    vecs[7] = '{11'sd8,     4'd4,  12'h008};
    vecs[8] = '{11'sd1023,  4'd10, 12'h3FF};
    vecs[9] = '{-11'sd1024, 4'd11, 12'h3FF};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out", {out_valid, out_dc, out_eob, out_last, out_run, out_size, out_amp}, 32'h0);
    check("reset_in_ready", in_ready, 1);

    fork
      monitor_loop();
      ready_loop();
    join_none
    @(posedge clk);
    #1;

    // DC=20 from predictor 0, then 63 zeros
    clear_blk(); blk[0] = 11'sd20;
    push(1, 0, 0, 4'd0, 4'd5, 12'h014);
    push(0, 1, 1, 4'd0, 4'd0, 12'h000);
    rx0 = rx_cnt;
    send_block(1'b0); wait_drain();
    check("s1_count", rx_cnt - rx0, 2);

    // DC=17 after 20: diff -3
    clear_blk(); blk[0] = 11'sd17;
    push(1, 0, 0, 4'd0, 4'd2, 12'h000);
    push(0, 1, 1, 4'd0, 4'd0, 12'h000);
    send_block(1'b0); wait_drain();

    // DC=17 with predictor cleared: diff 17
    push(1, 0, 0, 4'd0, 4'd5, 12'h011);
    push(0, 1, 1, 4'd0, 4'd0, 12'h000);
    send_block(1'b1); wait_drain();

    // long zero run split by two ZRLs
    clear_blk(); blk[1] = 11'sd1; blk[36] = -11'sd1;
    push(1, 0, 0, 4'd0,  4'd0, 12'h000);
    push(0, 0, 0, 4'd0,  4'd1, 12'h001);
    push(0, 0, 0, 4'd15, 4'd0, 12'h000);
    push(0, 0, 0, 4'd15, 4'd0, 12'h000);
    push(0, 0, 0, 4'd2,  4'd1, 12'h000);
    push(0, 1, 1, 4'd0,  4'd0, 12'h000);
    lowrdy_cnt = 0; done_cnt = 0; track_en = 1'b1;
    send_block(1'b1); wait_drain();
    track_en = 1'b0;
    check("zrl_in_ready_low", lowrdy_cnt, 3);
`ifdef JPEG_RLE_STATS_EN
    check("stats_done_pulses", done_cnt, 1);
    check("stats_nz_cnt", blk_nz_cnt, 2);
`endif

    // table: single AC at idx1, DC 0 with cleared predictor
    for (int v = 0; v < 10; v++) begin
      clear_blk(); blk[1] = vecs[v].ac;
      push(1, 0, 0, 4'd0, 4'd0, 12'h000);
      push(0, 0, 0, 4'd0, vecs[v].size, vecs[v].amp);
      push(0, 1, 1, 4'd0, 4'd0, 12'h000);
      send_block(1'b1); wait_drain();
    end

    // DC difference extremes: +1023, -2047, +2047
    clear_blk(); blk[0] = 11'sd1023;
    push(1, 0, 0, 4'd0, 4'd10, 12'h3FF); push(0, 1, 1, 4'd0, 4'd0, 12'h000);
    send_block(1'b0); wait_drain();
    blk[0] = -11'sd1024;
    push(1, 0, 0, 4'd0, 4'd11, 12'h000); push(0, 1, 1, 4'd0, 4'd0, 12'h000);
    send_block(1'b0); wait_drain();
    blk[0] = 11'sd1023;
    push(1, 0, 0, 4'd0, 4'd11, 12'h7FF); push(0, 1, 1, 4'd0, 4'd0, 12'h000);
    send_block(1'b0); wait_drain();

    // only the last coefficient nonzero: three ZRLs then a last symbol, no EOB
    clear_blk(); blk[63] = 11'sd3;
    push(1, 0, 0, 4'd0,  4'd0, 12'h000);
    push(0, 0, 0, 4'd15, 4'd0, 12'h000);
    push(0, 0, 0, 4'd15, 4'd0, 12'h000);
    push(0, 0, 0, 4'd15, 4'd0, 12'h000);
    push(0, 0, 1, 4'd14, 4'd2, 12'h003);
    send_block(1'b1); wait_drain();

    // all 64 coefficients = 1 under random back-pressure
    for (int i = 0; i < 64; i++) blk[i] = 11'sd1;
    push(1, 0, 0, 4'd0, 4'd1, 12'h001);
    for (int i = 1; i < 64; i++) push(0, 0, (i == 63), 4'd0, 4'd1, 12'h001);
    ready_rand = 1'b1;
    rx0 = rx_cnt;
    send_block(1'b0); wait_drain();
    ready_rand = 1'b0; ready_hold = 1'b1;
    @(posedge clk); #1;
    check("all_ones_count", rx_cnt - rx0, 64);

    // idx24..63 zero: no ZRL, only EOB
    clear_blk(); blk[0] = 11'sd1;
    for (int i = 1; i < 24; i++) blk[i] = 11'sd2;
    push(1, 0, 0, 4'd0, 4'd0, 12'h000);
    for (int i = 1; i < 24; i++) push(0, 0, 0, 4'd0, 4'd2, 12'h002);
    push(0, 1, 1, 4'd0, 4'd0, 12'h000);
    rx0 = rx_cnt;
    send_block(1'b0); wait_drain();
    check("trail_zero_count", rx_cnt - rx0, 25);

    // asynchronous reset while a DC symbol is stalled
    ready_hold = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_coef = 11'sd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stall_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", {out_valid, out_dc, out_eob, out_last, out_run, out_size, out_amp}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; ready_hold = 1'b1;
    @(posedge clk); #1;
    clear_blk(); blk[0] = 11'sd7;
    push(1, 0, 0, 4'd0, 4'd3, 12'h007);
    push(0, 1, 1, 4'd0, 4'd0, 12'h000);
    rx0 = rx_cnt;
    send_block(1'b0); wait_drain();
    check("after_reset_count", rx_cnt - rx0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
